judge_vote_n: RTL

Parametrised N-judge voting console, the sequential successor of the three-input judge. After a start pulse it collects "pass" presses from N judges over a bounded window, latches each judge's first press, and counts the latched votes. It then publishes a held pass/fail verdict and vote count to the display and scoring logic downstream.

---
 rtl/judge_vote_n.sv | 132 +++++++++++++
 1 files changed

// File: rtl/judge_vote_n.sv
// N-judge voting console: opens a bounded vote window on start, latches first presses,
// then publishes a held verdict and count. Define JUDGE_CHIEF_VETO_EN to give judge 0 a veto.
module judge_vote_n #(
    parameter int N_JUDGES   = 5,
    parameter int THRESH     = 3,
    parameter int WINDOW_CYC = 16,
    parameter int HOLD_CYC   = 8,
    localparam int CW        = $clog2(N_JUDGES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_JUDGES-1:0] vote,
    output logic [N_JUDGES-1:0] voted,
    output logic                busy,
    output logic                result_valid,
    output logic                pass,
    output logic [CW-1:0]       count
);

    // One down-counter serves both the vote window and the result hold.
    localparam int TMAX = (WINDOW_CYC > HOLD_CYC) ? WINDOW_CYC : HOLD_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] WIN_LOAD  = TW'(WINDOW_CYC - 1);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VOTE   = 2'd1,
        ST_EVAL   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

    state_t                state_r, state_nx_s;
    logic [TW-1:0]         timer_r, timer_nx_s;
    logic [N_JUDGES-1:0]   voted_r, voted_nx_s;
    logic [CW-1:0]         count_r, count_nx_s;
    logic                  pass_r, pass_nx_s;
    logic                  busy_r, result_valid_r;
    logic [CW-1:0]         pop_s;

    function automatic logic [CW-1:0] popcount(input logic [N_JUDGES-1:0] v);
        logic [CW-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_JUDGES; i++) begin
            acc = acc + CW'(v[i]);
        end
        return acc;
    endfunction

    // Next-state, window/hold counter and verdict computation.
    always_comb begin
        state_nx_s = state_r;
        timer_nx_s = timer_r;
        voted_nx_s = voted_r;
        count_nx_s = count_r;
        pass_nx_s  = pass_r;
        pop_s      = popcount(voted_r);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_VOTE;
                    timer_nx_s = WIN_LOAD;
                    voted_nx_s = '0;
                    count_nx_s = '0;
                    pass_nx_s  = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_VOTE: begin
                voted_nx_s = voted_r | vote;
                // Close early once every judge has voted; no later press can change the outcome.
                if ((timer_r == '0) || (&voted_nx_s)) begin
                    state_nx_s = ST_EVAL;
                end else begin
                    timer_nx_s = timer_r - TW'(1);
                end
            end
            ST_EVAL: begin
                count_nx_s = pop_s;
`ifdef JUDGE_CHIEF_VETO_EN
                pass_nx_s  = (pop_s >= THRESH_C) && voted_r[0];
`else
                pass_nx_s  = (pop_s >= THRESH_C);
`endif
                timer_nx_s = HOLD_LOAD;
                state_nx_s = ST_RESULT;
            end
            ST_RESULT: begin
                if (timer_r == '0) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    timer_nx_s = timer_r - TW'(1);
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; status flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            timer_r        <= '0;
            voted_r        <= '0;
            count_r        <= '0;
            pass_r         <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            timer_r        <= timer_nx_s;
            voted_r        <= voted_nx_s;
            count_r        <= count_nx_s;
            pass_r         <= pass_nx_s;
            busy_r         <= (state_nx_s != ST_IDLE);
            result_valid_r <= (state_nx_s == ST_RESULT);
        end
    end

    assign voted        = voted_r;
    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign pass         = pass_r;
    assign count        = count_r;

endmodule
